// File: rtl/eth_pkt_if_to_avalon_st_bridge.sv
// eth_pkt_if to Avalon-ST bridge with a registered two-entry skid buffer.
// Also monitors framing and keeps packet/error counters.
//
// Ports:
//   clk_i, rst_n_i              clock, async active-low reset
//   pkt_data_i .. pkt_mod_i     eth_pkt_if input beat
//   pkt_ready_o                 registered input ready
//   st_*                        Avalon-ST source, readyLatency 0
//   cnt_clr_i                   sync clear of both counters
//   pkt_cnt_o                   forwarded eop count (wrapping)
//   err_cnt_o                   framing error count (saturating)
//   err_sop_o, err_orphan_o     registered framing error strobes
module eth_pkt_if_to_avalon_st_bridge #(
  parameter int DATA_W      = 64,
  parameter int BYTES       = DATA_W / 8,
  parameter int MOD_W       = $clog2(BYTES),
  parameter bit DROP_ORPHAN = 1'b1,
  parameter int PKT_CNT_W   = 32,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DATA_W-1:0]    pkt_data_i,
  input  logic                 pkt_val_i,
  input  logic                 pkt_sop_i,
  input  logic                 pkt_eop_i,
  input  logic [MOD_W-1:0]     pkt_mod_i,
  output logic                 pkt_ready_o,
  output logic [DATA_W-1:0]    st_data_o,
  output logic                 st_valid_o,
  output logic                 st_startofpacket_o,
  output logic                 st_endofpacket_o,
  output logic [MOD_W-1:0]     st_empty_o,
  input  logic                 st_ready_i,
  input  logic                 cnt_clr_i,
  output logic [PKT_CNT_W-1:0] pkt_cnt_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 err_sop_o,
  output logic                 err_orphan_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  empty;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  beat_t in_beat;
  logic  main_v_q, main_v_d;
  logic  skid_v_q, skid_v_d;
  logic  rdy_q;
  logic  in_pkt_q, in_pkt_d;
  logic  err_sop_q, err_orph_q;
  logic  accept, xfer;
  logic  is_err_sop, is_orphan;
  logic  wr;

  logic [PKT_CNT_W-1:0] pkt_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign accept = pkt_val_i & rdy_q;
  assign xfer   = main_v_q & st_ready_i;

  assign is_err_sop = accept & pkt_sop_i & in_pkt_q;
  assign is_orphan  = accept & ~pkt_sop_i & ~in_pkt_q;
  // Dropped orphans are still accepted, just never buffered.
  assign wr = accept & ~(is_orphan & DROP_ORPHAN);

  // mod counts valid bytes, empty counts unused ones; only eop beats carry it.
  always_comb begin
    in_beat      = '0;
    in_beat.data = pkt_data_i;
    in_beat.sop  = pkt_sop_i;
    in_beat.eop  = pkt_eop_i;
    if (pkt_eop_i && pkt_mod_i != '0)
      in_beat.empty = MOD_W'(BYTES) - pkt_mod_i;
  end

  // Ready is registered from skid occupancy, so an accept
  // can only happen while skid is empty.
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (xfer) begin
      main_v_d = skid_v_q;
      if (skid_v_q) main_d = skid_q;
      skid_v_d = 1'b0;
    end
    if (wr) begin
      if (!main_v_q || xfer) begin
        main_d   = in_beat;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_beat;
        skid_v_d = 1'b1;
      end
    end
  end

  always_comb begin
    in_pkt_d = in_pkt_q;
    if (wr) in_pkt_d = (pkt_sop_i | in_pkt_q) & ~pkt_eop_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      rdy_q      <= 1'b0;
      in_pkt_q   <= 1'b0;
      err_sop_q  <= 1'b0;
      err_orph_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      rdy_q      <= ~skid_v_d;
      in_pkt_q   <= in_pkt_d;
      err_sop_q  <= is_err_sop;
      err_orph_q <= is_orphan;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (xfer && main_q.eop)
        pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
      if ((err_sop_q || err_orph_q) && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign pkt_ready_o        = rdy_q;
  assign st_data_o          = main_q.data;
  assign st_valid_o         = main_v_q;
  assign st_startofpacket_o = main_q.sop;
  assign st_endofpacket_o   = main_q.eop;
  assign st_empty_o         = main_q.empty;
  assign pkt_cnt_o          = pkt_cnt_q;
  assign err_cnt_o          = err_cnt_q;
  assign err_sop_o          = err_sop_q;
  assign err_orphan_o       = err_orph_q;

endmodule

// File: doc/eth_pkt_if_to_avalon_st_bridge.md
Name: eth_pkt_if_to_avalon_st_bridge

Overview:
Parametrised successor of the fixed 64-bit eth_pkt_if→Avalon-ST adapter. It converts an eth_pkt_if-style stream of data/val/sop/eop/mod/ready into Avalon-ST (readyLatency 0) for any byte-multiple width. It inserts a two-entry skid buffer so that every output and the upstream ready are registered, which breaks the ready timing path. It also monitors framing, optionally drops orphan beats, and keeps packet and error counters for CSR readout.

Parameters:
DATA_W, 64, data width in bits; multiple of 8, >= 16
BYTES, DATA_W/8, derived: bytes per word
MOD_W, $clog2(BYTES), derived: width of mod and empty
DROP_ORPHAN, 1, 1 = accept and discard beats outside a packet; 0 = forward them
PKT_CNT_W, 32, packet counter width
ERR_CNT_W, 16, error counter width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous reset, active low
pkt_data_i  in  DATA_W  input data, first byte in MSB lane
pkt_val_i  in  1  input beat valid
pkt_sop_i  in  1  start of packet
pkt_eop_i  in  1  end of packet
pkt_mod_i  in  MOD_W  valid bytes in eop word; 0 = all BYTES valid
pkt_ready_o  out  1  input ready (registered)
st_data_o  out  DATA_W  Avalon-ST data
st_valid_o  out  1  Avalon-ST valid
st_startofpacket_o  out  1  Avalon-ST sop
st_endofpacket_o  out  1  Avalon-ST eop
st_empty_o  out  MOD_W  Avalon-ST empty
st_ready_i  in  1  Avalon-ST ready
cnt_clr_i  in  1  synchronous clear of both counters
pkt_cnt_o  out  PKT_CNT_W  forwarded eop count, wrapping
err_cnt_o  out  ERR_CNT_W  framing error count, saturating
err_sop_o  out  1  one-cycle strobe: sop accepted while inside a packet
err_orphan_o  out  1  one-cycle strobe: non-sop beat accepted while idle

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - st_valid_o=0, pkt_ready_o=0, skid buffer empty, in_pkt=0, counters=0, strobes=0.
  - Data, sop, eop and empty outputs are 0.
  - pkt_ready_o goes to 1 on the first clk_i edge after reset deasserts.
- Input beat accepted when pkt_val_i & pkt_ready_o.
- Output beat transferred when st_valid_o & st_ready_i.
- Empty conversion at accept: empty = (mod==0) ? 0 : BYTES-mod, in MOD_W bits.
  - On a non-eop beat, empty is forced to 0 and mod is ignored.
- Skid buffer, entries main and skid:
  - Main drives the st_* outputs.
  - Accepted beat goes to main if main is empty or is transferring this cycle; otherwise it goes to skid.
  - When main transfers and skid is full, skid moves to main.
  - pkt_ready_o(next) = !skid_full(next).
  - Latency input→output: 1 cycle.
  - Throughput: 1 beat/cycle with st_ready_i held high.
  - Under backpressure, no beat is lost or duplicated, and order is preserved.
- Framing monitor. Evaluated on accepted beats only, with state in_pkt:
  - sop & in_pkt: err_sop_o=1. The beat is forwarded and starts a new packet; in_pkt stays 1 unless eop.
  - !sop & !in_pkt: err_orphan_o=1. The beat is dropped if DROP_ORPHAN=1 (not written to the buffer, still accepted); otherwise it is forwarded.
  - sop & eop: single-word packet; in_pkt unchanged at 0.
  - in_pkt(next) = (sop | in_pkt) & !eop, for non-dropped beats.
  - Strobes are registered and appear 1 cycle after accept.
- Counters:
  - pkt_cnt_o increments on each output transfer with eop; wraps at 2^PKT_CNT_W.
  - err_cnt_o increments by 1 per error strobe (at most 1 per cycle) and saturates at all ones.
  - cnt_clr_i has priority over increment in the same cycle.
- Concurrent events:
  - Accept and transfer in the same cycle with skid empty: main is replaced; pkt_ready_o stays 1.
  - Accept while main is stalled and skid is empty: beat goes to skid; pkt_ready_o=0 next cycle.
- Reset mid-packet: in-flight beats are discarded and in_pkt clears. The first post-reset non-sop beat counts as orphan.

Test Plan:
1. DATA_W=64, st_ready_i=1, 3-beat packet with mod=0,0,5 → output 1 cycle later with empty=0,0,3, sop on beat 0, eop on beat 2; pkt_cnt_o=1; pkt_ready_o constant 1.
2. DATA_W=128, single-word packet sop=eop=1 with mod=1, then mod=0 → empty=15, then empty=0; the mod of a non-eop beat (mod=7) gives empty=0.
3. Random st_ready_i (50%), 1000 random packets → output sequence identical to input; pkt_ready_o low only when both entries are full; pkt_cnt_o=1000.
4. DROP_ORPHAN=1: beat without sop while idle → err_orphan_o pulse, beat absent at output, err_cnt_o=1; with DROP_ORPHAN=0 the beat is forwarded.
5. sop, data, sop, eop → err_sop_o pulse on the third beat, all 4 beats forwarded, err_cnt_o=1, pkt_cnt_o=1.
6. err_cnt_o preloaded to 0xFFFF plus an error → stays 0xFFFF; cnt_clr_i together with an eop transfer → both counters 0. rst_n_i pulsed mid-packet with st_ready_i=0 → outputs 0 immediately (asynchronously), no stale beat after release.
